// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: multi-issue hazard detector with a per-register countdown
// scoreboard. It issues a contiguous prefix of the IF/ID bundle, splits the
// bundle on intra-bundle RAW/WAW hazards and stalls on scoreboard conflicts.
// Optional feature macro: HAZARD_SCOREBOARD_FORWARD_EN. When it is defined,
// loads use LOAD_BUB and ALU writes use ALU_BUB. When it is undefined, every
// write uses WB_BUB.
module hazard_scoreboard #(
  parameter int ISSUE_W     = 2,
  parameter int RA_W        = 3,
  parameter int ZERO_REG    = 1,
  parameter int LOAD_BUB    = 1,
  parameter int ALU_BUB     = 0,
  parameter int WB_BUB      = 2,
  parameter int STALL_LIMIT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ISSUE_W-1:0]      slot_vld,
  input  logic [ISSUE_W*RA_W-1:0] slot_rs1,
  input  logic [ISSUE_W*RA_W-1:0] slot_rs2,
  input  logic [ISSUE_W-1:0]      slot_use1,
  input  logic [ISSUE_W-1:0]      slot_use2,
  input  logic [ISSUE_W-1:0]      slot_wr,
  input  logic [ISSUE_W*RA_W-1:0] slot_rd,
  input  logic [ISSUE_W-1:0]      slot_load,
  output logic [ISSUE_W-1:0]      issue_mask,
  output logic                    split,
  output logic                    PCWrite,
  output logic                    IF_ID_Write,
  output logic                    CntrlSel,
  output logic [15:0]             stall_cnt,
  output logic                    wdog_err
);

  localparam int NREGS = 2 ** RA_W;
`ifdef HAZARD_SCOREBOARD_FORWARD_EN
  localparam int MAXB = (LOAD_BUB > ALU_BUB) ? LOAD_BUB : ALU_BUB;
  localparam int unused_wb_bub = WB_BUB;
`else
  localparam int MAXB = WB_BUB;
  localparam int unused_fwd_bubs = LOAD_BUB + ALU_BUB;
`endif
  localparam int CW    = (MAXB < 1) ? 1 : $clog2(MAXB + 1);
  localparam int RUN_W = $clog2(STALL_LIMIT + 1);

  logic [CW-1:0]    r_busy [NREGS];
  logic [15:0]      r_stall_cnt;
  logic [RUN_W-1:0] r_run;
  logic             r_wdog;

  logic [RA_W-1:0]  w_rs1 [ISSUE_W];
  logic [RA_W-1:0]  w_rs2 [ISSUE_W];
  logic [RA_W-1:0]  w_rd  [ISSUE_W];
  logic [CW-1:0]    w_bub [ISSUE_W];
  logic [ISSUE_W-1:0] w_use1_live, w_use2_live, w_rd_live;
  logic [ISSUE_W-1:0] w_vld, w_issue;
  logic             w_chain, w_hz;

`ifndef HAZARD_SCOREBOARD_FORWARD_EN
  logic w_unused_load;
  assign w_unused_load = ^slot_load;
`endif

  // Unpack slot fields and mask out r0 accesses when r0 is hard-wired.
  always_comb begin
    w_use1_live = '0;
    w_use2_live = '0;
    w_rd_live   = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      w_rs1[i] = slot_rs1[i*RA_W +: RA_W];
      w_rs2[i] = slot_rs2[i*RA_W +: RA_W];
      w_rd[i]  = slot_rd[i*RA_W +: RA_W];
      w_use1_live[i] = slot_use1[i] && !((ZERO_REG != 0) && (slot_rs1[i*RA_W +: RA_W] == '0));
      w_use2_live[i] = slot_use2[i] && !((ZERO_REG != 0) && (slot_rs2[i*RA_W +: RA_W] == '0));
      w_rd_live[i]   = slot_wr[i]   && !((ZERO_REG != 0) && (slot_rd[i*RA_W +: RA_W] == '0));
`ifdef HAZARD_SCOREBOARD_FORWARD_EN
      w_bub[i] = slot_load[i] ? CW'(LOAD_BUB) : CW'(ALU_BUB);
`else
      w_bub[i] = CW'(WB_BUB);
`endif
    end
  end

  // Issue decision: walk slots oldest first, stopping at the first one that cannot go.
  always_comb begin
    w_vld   = reset ? '0 : slot_vld;
    w_issue = '0;
    w_chain = 1'b1;
    w_hz    = 1'b0;
    for (int i = 0; i < ISSUE_W; i++) begin
      w_hz = (w_use1_live[i] && (r_busy[w_rs1[i]] != '0)) ||
             (w_use2_live[i] && (r_busy[w_rs2[i]] != '0)) ||
             (slot_wr[i] && (r_busy[w_rd[i]] > w_bub[i]));
      for (int j = 0; j < i; j++) begin
        if (w_vld[j] && w_rd_live[j]) begin
          if ((w_use1_live[i] && (w_rs1[i] == w_rd[j])) ||
              (w_use2_live[i] && (w_rs2[i] == w_rd[j])) ||
              (slot_wr[i] && (w_rd[i] == w_rd[j])))
            w_hz = 1'b1;
        end
      end
      w_issue[i] = w_chain && w_vld[i] && !w_hz;
      w_chain    = w_issue[i];
    end
    issue_mask  = w_issue;
    CntrlSel    = (w_vld != '0) && (w_issue == '0);
    split       = (w_issue != '0) && (w_issue != w_vld);
    PCWrite     = (w_issue == w_vld);
    IF_ID_Write = !CntrlSel;
  end

  // Scoreboard: count every pending write down, reload on issue (higher slot wins).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) r_busy[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++)
        if (r_busy[r] != '0) r_busy[r] <= r_busy[r] - CW'(1);
      for (int i = 0; i < ISSUE_W; i++)
        if (w_issue[i] && w_rd_live[i]) r_busy[w_rd[i]] <= w_bub[i];
    end
  end

  // Saturating count of all stall cycles.
  always_ff @(posedge clk) begin
    if (reset)
      r_stall_cnt <= '0;
    else if (CntrlSel && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  // Watchdog: length of the current stall run, sticky error once it hits the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_run  <= '0;
      r_wdog <= 1'b0;
    end else if (CntrlSel) begin
      if (r_run != RUN_W'(STALL_LIMIT)) r_run <= r_run + RUN_W'(1);
      if (r_run >= RUN_W'(STALL_LIMIT - 1)) r_wdog <= 1'b1;
    end else if (w_issue != '0) begin
      r_run <= '0;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign wdog_err  = r_wdog;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed scenarios with literal expectations
// plus randomized bundles checked every cycle against a register-ready-time model.
module tb_hazard_scoreboard;

  localparam int IW = 2;
  localparam int RW = 3;
  localparam int ZR = 1;
  localparam int LB = 1;
  localparam int AB = 0;
  localparam int WB = 2;
  localparam int SL = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [IW-1:0] slot_vld = '0, slot_use1 = '0, slot_use2 = '0, slot_wr = '0, slot_load = '0;
  logic [IW*RW-1:0] slot_rs1 = '0, slot_rs2 = '0, slot_rd = '0;
  logic [IW-1:0] issue_mask;
  logic          split, PCWrite, IF_ID_Write, CntrlSel, wdog_err;
  logic [15:0]   stall_cnt;

  hazard_scoreboard #(
    .ISSUE_W(IW), .RA_W(RW), .ZERO_REG(ZR), .LOAD_BUB(LB),
    .ALU_BUB(AB), .WB_BUB(WB), .STALL_LIMIT(SL)
  ) dut (
    .clk(clk), .reset(reset), .slot_vld(slot_vld), .slot_rs1(slot_rs1),
    .slot_rs2(slot_rs2), .slot_use1(slot_use1), .slot_use2(slot_use2),
    .slot_wr(slot_wr), .slot_rd(slot_rd), .slot_load(slot_load),
    .issue_mask(issue_mask), .split(split), .PCWrite(PCWrite),
    .IF_ID_Write(IF_ID_Write), .CntrlSel(CntrlSel), .stall_cnt(stall_cnt),
    .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // ready_at[r]: first cycle a reader of r may issue.
  int ready_at [8];
  int cyc = 0;
  int m_stall = 0;
  int m_run = 0;
  bit m_wdog = 1'b0;

  function automatic int bub_of(input logic is_load);
`ifdef HAZARD_SCOREBOARD_FORWARD_EN
    return is_load ? LB : AB;
`else
    return WB;
`endif
  endfunction

  function automatic bit is_r0(input int r);
    return (ZR != 0) && (r == 0);
  endfunction

  always @(negedge clk) begin
    logic [IW-1:0] e_mask;
    bit stop, hz;
    int nv, ni, rs1, rs2, rd, b, rdj;
    bit e_cs, e_split, e_pcw, e_ifid;
    e_mask = '0;
    nv = 0;
    if (!reset) begin
      stop = 0;
      for (int i = 0; i < IW; i++) begin
        if (slot_vld[i]) nv++;
        if (!stop) begin
          if (!slot_vld[i]) stop = 1;
          else begin
            rs1 = int'(slot_rs1[i*RW +: RW]);
            rs2 = int'(slot_rs2[i*RW +: RW]);
            rd  = int'(slot_rd[i*RW +: RW]);
            b   = bub_of(slot_load[i]);
            hz  = 0;
            if (slot_use1[i] && !is_r0(rs1) && (ready_at[rs1] - cyc > 0)) hz = 1;
            if (slot_use2[i] && !is_r0(rs2) && (ready_at[rs2] - cyc > 0)) hz = 1;
            if (slot_wr[i] && (ready_at[rd] - cyc > b)) hz = 1;
            for (int j = 0; j < i; j++) begin
              rdj = int'(slot_rd[j*RW +: RW]);
              if (slot_wr[j] && !is_r0(rdj)) begin
                if (slot_use1[i] && !is_r0(rs1) && rs1 == rdj) hz = 1;
                if (slot_use2[i] && !is_r0(rs2) && rs2 == rdj) hz = 1;
                if (slot_wr[i] && rd == rdj) hz = 1;
              end
            end
            if (hz) stop = 1;
            else e_mask[i] = 1'b1;
          end
        end
      end
    end
    ni = 0;
    for (int i = 0; i < IW; i++) if (e_mask[i]) ni++;
    e_cs    = (nv > 0) && (ni == 0);
    e_split = (ni > 0) && (ni < nv);
    e_pcw   = (ni == nv);
    e_ifid  = !e_cs;
    if (checking) begin
      chk("issue_mask", 32'(issue_mask), 32'(e_mask));
      chk("CntrlSel", 32'(CntrlSel), 32'(e_cs));
      chk("split", 32'(split), 32'(e_split));
      chk("PCWrite", 32'(PCWrite), 32'(e_pcw));
      chk("IF_ID_Write", 32'(IF_ID_Write), 32'(e_ifid));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("wdog_err", 32'(wdog_err), 32'(m_wdog));
    end
    if (reset) begin
      for (int r = 0; r < 8; r++) ready_at[r] = 0;
      m_stall = 0;
      m_run = 0;
      m_wdog = 0;
    end else begin
      for (int i = 0; i < IW; i++) begin
        rd = int'(slot_rd[i*RW +: RW]);
        if (e_mask[i] && slot_wr[i] && !is_r0(rd))
          ready_at[rd] = cyc + bub_of(slot_load[i]) + 1;
      end
      if (e_cs) begin
        if (m_stall < 65535) m_stall++;
        m_run = (m_run + 1 > SL) ? SL : m_run + 1;
        if (m_run >= SL) m_wdog = 1;
      end else if (ni > 0) begin
        m_run = 0;
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_in();
    slot_vld = '0; slot_use1 = '0; slot_use2 = '0; slot_wr = '0; slot_load = '0;
    slot_rs1 = '0; slot_rs2 = '0; slot_rd = '0;
  endtask

  task automatic set_slot(input int i, input int rs1, input bit u1, input int rs2,
                          input bit u2, input bit wr, input int rd, input bit ld);
    slot_vld[i]  = 1'b1;
    slot_rs1[i*RW +: RW] = RW'(rs1);
    slot_rs2[i*RW +: RW] = RW'(rs2);
    slot_rd[i*RW +: RW]  = RW'(rd);
    slot_use1[i] = u1;
    slot_use2[i] = u2;
    slot_wr[i]   = wr;
    slot_load[i] = ld;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checking = 1'b1;
    @(negedge clk);
    chk("rst_mask", 32'(issue_mask), 32'h0);
    chk("rst_pcw", 32'(PCWrite), 32'h1);
    chk("rst_ifid", 32'(IF_ID_Write), 32'h1);
    chk("rst_cs", 32'(CntrlSel), 32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'h0);
    chk("rst_wdog", 32'(wdog_err), 32'h0);

`ifdef HAZARD_SCOREBOARD_FORWARD_EN
    // Load r3, then consumer: one bubble.
    nxt(); set_slot(0, 1, 1, 0, 0, 1, 3, 1);
    @(negedge clk); chk("ld_issue", 32'(issue_mask), 32'h1);
    nxt(); clear_in(); set_slot(0, 3, 1, 0, 0, 1, 4, 0);
    @(negedge clk); chk("ld_use_cs", 32'(CntrlSel), 32'h1);
    chk("ld_use_mask", 32'(issue_mask), 32'h0);
    nxt();
    @(negedge clk); chk("ld_use_go", 32'(issue_mask), 32'h1);
    chk("ld_use_stall", 32'(stall_cnt), 32'h1);
`else
    // add r5 then a consumer of r5: two stalls, watchdog (limit 2) fires.
    nxt(); set_slot(0, 1, 1, 0, 0, 1, 5, 0);
    @(negedge clk); chk("wb_issue", 32'(issue_mask), 32'h1);
    nxt(); clear_in(); set_slot(0, 5, 1, 0, 0, 1, 6, 0);
    @(negedge clk); chk("wb_stall1", 32'(CntrlSel), 32'h1);
    chk("wb_stall1_mask", 32'(issue_mask), 32'h0);
    nxt();
    @(negedge clk); chk("wb_stall2", 32'(CntrlSel), 32'h1);
    nxt();
    @(negedge clk); chk("wb_go", 32'(issue_mask), 32'h1);
    chk("wb_stall_cnt", 32'(stall_cnt), 32'h2);
    chk("wb_wdog", 32'(wdog_err), 32'h1);
`endif
    nxt(); do_reset();
    @(negedge clk);
    chk("rst2_wdog", 32'(wdog_err), 32'h0);
    chk("rst2_stall", 32'(stall_cnt), 32'h0);

    // Intra-bundle RAW: {add r2<-r1, sub r4<-r2}.
    nxt(); set_slot(0, 1, 1, 0, 0, 1, 2, 0); set_slot(1, 2, 1, 0, 0, 1, 4, 0);
    @(negedge clk);
    chk("split_mask", 32'(issue_mask), 32'h1);
    chk("split_flag", 32'(split), 32'h1);
    chk("split_ifid", 32'(IF_ID_Write), 32'h1);
    chk("split_pcw", 32'(PCWrite), 32'h0);
`ifdef HAZARD_SCOREBOARD_FORWARD_EN
    nxt(); clear_in(); set_slot(0, 2, 1, 0, 0, 1, 4, 0);
    @(negedge clk); chk("split_next", 32'(issue_mask), 32'h1);
`endif
    nxt(); do_reset();

    // r0 reads and writes never stall.
    for (int k = 0; k < 3; k++) begin
      set_slot(0, 0, 1, 0, 1, 1, 0, 0); set_slot(1, 0, 1, 0, 0, 1, 0, 1);
      @(negedge clk); chk("r0_mask", 32'(issue_mask), 32'h3);
      nxt();
    end
    do_reset();

    // Reset right after a load: consumer must not stall afterwards.
    set_slot(0, 1, 1, 0, 0, 1, 3, 1);
    @(negedge clk); chk("rl_issue", 32'(issue_mask), 32'h1);
    nxt(); clear_in(); set_slot(0, 3, 1, 0, 0, 1, 4, 0); reset = 1'b1;
    @(negedge clk);
    chk("rl_rst_mask", 32'(issue_mask), 32'h0);
    chk("rl_rst_cs", 32'(CntrlSel), 32'h0);
    chk("rl_rst_pcw", 32'(PCWrite), 32'h1);
    nxt(); reset = 1'b0;
    @(negedge clk);
    chk("rl_after_mask", 32'(issue_mask), 32'h1);
    chk("rl_after_cs", 32'(CntrlSel), 32'h0);

    // Randomized bundles on a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      int sel;
      nxt();
      clear_in();
      reset = ($urandom_range(0, 99) == 0);
      sel = $urandom_range(0, 3);
      for (int i = 0; i < IW; i++) begin
        if ((i == 0 && sel != 0) || (i == 1 && sel >= 2))
          set_slot(i, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
      end
    end
    nxt();
    clear_in();
    reset = 1'b0;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised, clocked successor to the combinational dual-issue hazard detector. It tracks pending register writes in a per-register countdown scoreboard and issues up to ISSUE_W instructions per cycle from the IF/ID bundle. It splits a bundle on intra-bundle RAW/WAW hazards and stalls on scoreboard conflicts. It sits between the IF/ID register and the ID/EX register, and drives the PC/IF_ID write enables and the control-bubble select.

## Interface
- ISSUE_W, 2: issue slots per bundle; slot 0 is oldest in program order.
- RA_W, 3: register address width; NREGS = 2**RA_W.
- ZERO_REG, 1: when 1, register 0 is never marked busy.
- LOAD_BUB, 1: bubbles a load's consumer needs (forwarding build).
- ALU_BUB, 0: bubbles an ALU result's consumer needs (forwarding build).
- WB_BUB, 2: bubbles any consumer needs when forwarding is compiled out.
- STALL_LIMIT, 64: consecutive full-stall cycles before the watchdog fires.
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- slot_vld  in  ISSUE_W  slot holds a valid instruction.
- slot_rs1, slot_rs2  in  ISSUE_W*RA_W  source registers, packed; slot i at [i*RA_W +: RA_W].
- slot_use1, slot_use2  in  ISSUE_W  source actually read.
- slot_wr  in  ISSUE_W  slot writes slot_rd.
- slot_rd  in  ISSUE_W*RA_W  destination register, packed.
- slot_load  in  ISSUE_W  slot is a load.
- issue_mask  out  ISSUE_W  slots issued this cycle; always a contiguous prefix from slot 0.
- split  out  1  partial issue; the front end re-presents the first unissued slot as slot 0.
- PCWrite, IF_ID_Write  out  1  both 1 only when every valid slot issued.
- CntrlSel  out  1  1 injects a bubble into ID/EX; equals the stall condition (no slot issued).
- stall_cnt  out  16  saturating count of cycles with CntrlSel=1.
- wdog_err  out  1  sticky; set after STALL_LIMIT consecutive stall cycles.

## Operation
- The scoreboard holds one counter busy[r] per register, width clog2(max bubble+1). A register is busy when busy[r] != 0.
- Slot i is blocked by any of the following:
  - a used source is busy;
  - slot_wr and busy[rd] > its own bubble count (WAW against an in-flight write);
  - an older valid unissued-eligible slot j<i writes a register that slot i reads (RAW) or writes (WAW);
  - any older slot is blocked.
- The issue_mask prefix ends at the first blocked valid slot. Invalid slots never block and are never masked in.
- If slot 0 is blocked: issue_mask=0, CntrlSel=1, PCWrite=0, IF_ID_Write=0.
- If 0 < issued < number of valid slots: split=1, PCWrite=0, IF_ID_Write=1 (front end shifts), CntrlSel=0.
- Scoreboard update at each edge:
  - every nonzero counter decrements by 1;
  - for each issued slot with slot_wr, busy[rd] is loaded with its bubble count;
  - a load overrides the decrement in the same cycle;
  - for same-rd loads within one bundle, the higher slot wins (unreachable in practice, since WAW splits the bundle).
- When ZERO_REG=1, reads of r0 never block and writes to r0 never load a counter.
- stall_cnt increments on CntrlSel=1 and holds at 16'hFFFF.
- A run counter counts consecutive CntrlSel=1 cycles and clears on any issue. wdog_err sets when the run reaches STALL_LIMIT and stays set until reset.

## Timing
- Issue decision, PCWrite, IF_ID_Write, CntrlSel and split are combinational from inputs and the scoreboard, within the same cycle.
- Scoreboard, stall_cnt and wdog_err are registered; they are visible the cycle after the issue that causes them.
- A producer issued in cycle t with bubble count B lets a dependent instruction issue no earlier than cycle t+B+1.
- Reset values: every busy[r]=0, stall_cnt=0, run counter=0, wdog_err=0. With empty inputs the combinational outputs are issue_mask=0, split=0, PCWrite=1, IF_ID_Write=1, CntrlSel=0.
- Reset asserted mid-operation clears all in-flight tracking on that edge, and inputs are ignored that cycle. The outputs in that cycle are the same as with empty inputs: issue_mask=0, split=0, PCWrite=1, IF_ID_Write=1, CntrlSel=0.

## Configuration
- HAZARD_SCOREBOARD_FORWARD_EN defined: loads use LOAD_BUB and ALU writes use ALU_BUB. With ALU_BUB=0, ALU writes never mark a register busy, and intra-bundle RAW on an ALU producer still splits the bundle.
- Not defined: every write uses WB_BUB, and LOAD_BUB/ALU_BUB are ignored.

## Test plan
- Forwarding build, default parameters:
  - Load r3 in cycle 0, then an add reading r3 in slot 0 in cycle 1 -> cycle 1 CntrlSel=1, issue_mask=00; cycle 2 issue_mask=01.
  - Bundle {add r2<-r1, sub r4<-r2} -> issue_mask=01, split=1, IF_ID_Write=1, PCWrite=0; the next cycle issues sub.
- Non-forwarding build: add r5 issued, then a consumer of r5 -> two stall cycles, issues on the third cycle, stall_cnt=2.
- Writes and reads of r0 with ZERO_REG=1 on back-to-back cycles -> no stalls, issue_mask=11 every cycle.
- Consumer held on a busy register with the producer never retiring (scoreboard forced) for 64 cycles -> wdog_err=1 from cycle 64. Reset pulse -> wdog_err=0, busy cleared, stall_cnt=0.
- Load issued, reset asserted the next cycle, then the consumer -> no stall after reset.
